commit_lockstep_checker: RTL and testbench

COMMIT_LOCKSTEP_CHECKER -- requirements
Module: commit_lockstep_checker

---
 rtl/commit_lockstep_checker.sv | 197 +++++++++++++++++++
 tb/tb_commit_lockstep_checker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/commit_lockstep_checker.sv
// Lockstep checker: compares per-channel commit streams from a DUT and a golden model
// through skew FIFOs. Optional macro COMMIT_CMP_HALT_EN halts checking on the first error.
module commit_lockstep_checker #(
   parameter int NUM_CH  = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 64,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     en_i,
   input  logic [NUM_CH-1:0]        dut_vld_i,
   input  logic [NUM_CH-1:0]        ref_vld_i,
   input  logic [NUM_CH*ADDR_W-1:0] dut_addr_i,
   input  logic [NUM_CH*ADDR_W-1:0] ref_addr_i,
   input  logic [NUM_CH*DATA_W-1:0] dut_data_i,
   input  logic [NUM_CH*DATA_W-1:0] ref_data_i,
   output logic [1:0]               state_o,
   output logic [31:0]              match_cnt_o,
   output logic                     err_o,
   output logic [1:0]               err_code_o,
   output logic [CH_W-1:0]          err_ch_o,
   output logic [ADDR_W-1:0]        err_addr_o,
   output logic [DATA_W-1:0]        err_dut_data_o,
   output logic [DATA_W-1:0]        err_ref_data_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int EW = ADDR_W + DATA_W;
   localparam int LW = $clog2(TIMEOUT + 1);
`ifdef COMMIT_CMP_HALT_EN
   localparam bit HALT = 1'b1;
`else
   localparam bit HALT = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_FAIL = 2'b10} state_e;
   state_e state_q, state_d;

   logic                run;
   logic [NUM_CH-1:0]   pop, mism, ovf, tmo;
   logic [ADDR_W-1:0]   d_addr [NUM_CH];
   logic [DATA_W-1:0]   d_data [NUM_CH];
   logic [DATA_W-1:0]   r_data [NUM_CH];

   assign run = (state_q == S_RUN);

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [EW-1:0] dmem [DEPTH];
      logic [EW-1:0] rmem [DEPTH];
      logic [PW:0]   dwr_q, drd_q, rwr_q, rrd_q;
      logic [LW-1:0] lead_q;
      logic          d_empty, r_empty, d_full, r_full, d_push, r_push, d_wr, r_wr, one_side;
      logic [EW-1:0] d_head, r_head;

      assign d_empty  = (dwr_q == drd_q);
      assign r_empty  = (rwr_q == rrd_q);
      assign d_full   = (dwr_q[PW] != drd_q[PW]) && (dwr_q[PW-1:0] == drd_q[PW-1:0]);
      assign r_full   = (rwr_q[PW] != rrd_q[PW]) && (rwr_q[PW-1:0] == rrd_q[PW-1:0]);
      assign d_push   = run && dut_vld_i[gi];
      assign r_push   = run && ref_vld_i[gi];
      assign pop[gi]  = run && !d_empty && !r_empty;
      // a simultaneous pop frees the slot, so a push at full is only dropped without one
      assign d_wr     = d_push && (!d_full || pop[gi]);
      assign r_wr     = r_push && (!r_full || pop[gi]);
      assign ovf[gi]  = (d_push && d_full && !pop[gi]) || (r_push && r_full && !pop[gi]);
      assign d_head   = dmem[drd_q[PW-1:0]];
      assign r_head   = rmem[rrd_q[PW-1:0]];
      assign mism[gi] = pop[gi] && (d_head != r_head);
      assign one_side = d_empty ^ r_empty;
      assign tmo[gi]  = run && one_side && (lead_q == LW'(TIMEOUT - 1));

      assign d_addr[gi] = d_head[EW-1:DATA_W];
      assign d_data[gi] = d_head[DATA_W-1:0];
      assign r_data[gi] = r_head[DATA_W-1:0];

      always_ff @(posedge clk_i) begin
         if (d_wr) dmem[dwr_q[PW-1:0]] <= {dut_addr_i[gi*ADDR_W +: ADDR_W], dut_data_i[gi*DATA_W +: DATA_W]};
         if (r_wr) rmem[rwr_q[PW-1:0]] <= {ref_addr_i[gi*ADDR_W +: ADDR_W], ref_data_i[gi*DATA_W +: DATA_W]};
      end

      always_ff @(posedge clk_i or posedge reset_i) begin
         if (reset_i) begin
            dwr_q  <= '0;
            drd_q  <= '0;
            rwr_q  <= '0;
            rrd_q  <= '0;
            lead_q <= '0;
         end else if (state_q == S_IDLE) begin
            dwr_q  <= '0;
            drd_q  <= '0;
            rwr_q  <= '0;
            rrd_q  <= '0;
            lead_q <= '0;
         end else begin
            if (d_wr)    dwr_q <= dwr_q + 1'b1;
            if (r_wr)    rwr_q <= rwr_q + 1'b1;
            if (pop[gi]) begin
               drd_q <= drd_q + 1'b1;
               rrd_q <= rrd_q + 1'b1;
            end
            if (run && one_side)
               lead_q <= (lead_q == LW'(TIMEOUT)) ? lead_q : lead_q + 1'b1;
            else
               lead_q <= '0;
         end
      end
   end

   logic              err_q, err_d, new_err;
   logic [1:0]        err_code_q, err_code_d, code_c;
   logic [CH_W-1:0]   err_ch_q, err_ch_d, ch_c;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;
   logic [DATA_W-1:0] err_dut_q, err_dut_d, err_ref_q, err_ref_d;
   logic [31:0]       match_cnt_q, match_cnt_d, inc;
   logic [32:0]       cnt_sum;

   always_comb begin
      new_err     = |(mism | ovf | tmo);
      code_c      = 2'b00;
      ch_c        = '0;
      err_addr_d  = err_addr_q;
      err_dut_d   = err_dut_q;
      err_ref_d   = err_ref_q;
      inc         = '0;
      // later loops override earlier ones; descending order leaves the lowest channel
      for (int c = NUM_CH - 1; c >= 0; c--)
         if (tmo[c]) begin code_c = 2'b11; ch_c = CH_W'(c); end
      for (int c = NUM_CH - 1; c >= 0; c--)
         if (ovf[c]) begin code_c = 2'b10; ch_c = CH_W'(c); end
      for (int c = NUM_CH - 1; c >= 0; c--)
         if (mism[c]) begin code_c = 2'b01; ch_c = CH_W'(c); end
      for (int c = 0; c < NUM_CH; c++)
         inc = inc + 32'(pop[c] & ~mism[c]);

      err_d      = err_q;
      err_code_d = err_code_q;
      err_ch_d   = err_ch_q;
      if (new_err && !err_q) begin
         err_d      = 1'b1;
         err_code_d = code_c;
         err_ch_d   = ch_c;
         if (code_c == 2'b01) begin
            err_addr_d = d_addr[ch_c];
            err_dut_d  = d_data[ch_c];
            err_ref_d  = r_data[ch_c];
         end
      end

      cnt_sum     = {1'b0, match_cnt_q} + {1'b0, inc};
      match_cnt_d = match_cnt_q;
      if (!(HALT && new_err))
         match_cnt_d = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];

      state_d = state_q;
      case (state_q)
         S_IDLE:  if (en_i) state_d = S_RUN;
         S_RUN:   if (HALT && new_err) state_d = S_FAIL;
                  else if (!en_i)      state_d = S_IDLE;
         default: state_d = S_FAIL;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         match_cnt_q <= '0;
         err_q       <= 1'b0;
         err_code_q  <= '0;
         err_ch_q    <= '0;
         err_addr_q  <= '0;
         err_dut_q   <= '0;
         err_ref_q   <= '0;
      end else begin
         state_q     <= state_d;
         match_cnt_q <= match_cnt_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
         err_ch_q    <= err_ch_d;
         err_addr_q  <= err_addr_d;
         err_dut_q   <= err_dut_d;
         err_ref_q   <= err_ref_d;
      end
   end

   assign state_o        = state_q;
   assign match_cnt_o    = match_cnt_q;
   assign err_o          = err_q;
   assign err_code_o     = err_code_q;
   assign err_ch_o       = err_ch_q;
   assign err_addr_o     = err_addr_q;
   assign err_dut_data_o = err_dut_q;
   assign err_ref_data_o = err_ref_q;

endmodule

// File: tb/tb_commit_lockstep_checker.sv
// Directed bench for commit_lockstep_checker (default parameters); honours COMMIT_CMP_HALT_EN.
module tb_commit_lockstep_checker;

   logic        clk_i = 1'b0;
   logic        reset_i, en_i;
   logic [1:0]  dut_vld_i, ref_vld_i;
   logic [63:0] dut_addr_i, ref_addr_i, dut_data_i, ref_data_i;
   logic [1:0]  state_o;
   logic [31:0] match_cnt_o;
   logic        err_o;
   logic [1:0]  err_code_o;
   logic [0:0]  err_ch_o;
   logic [31:0] err_addr_o, err_dut_data_o, err_ref_data_o;

   int vectors = 0;
   int miscompares = 0;

`ifdef COMMIT_CMP_HALT_EN
   localparam logic [1:0] ST_AFTER_ERR = 2'b10;
`else
   localparam logic [1:0] ST_AFTER_ERR = 2'b01;
`endif

   commit_lockstep_checker dut (
      .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i),
      .dut_vld_i(dut_vld_i), .ref_vld_i(ref_vld_i),
      .dut_addr_i(dut_addr_i), .ref_addr_i(ref_addr_i),
      .dut_data_i(dut_data_i), .ref_data_i(ref_data_i),
      .state_o(state_o), .match_cnt_o(match_cnt_o), .err_o(err_o),
      .err_code_o(err_code_o), .err_ch_o(err_ch_o), .err_addr_o(err_addr_o),
      .err_dut_data_o(err_dut_data_o), .err_ref_data_o(err_ref_data_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1);
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic clear_in();
      dut_vld_i = '0; ref_vld_i = '0;
      dut_addr_i = '0; ref_addr_i = '0; dut_data_i = '0; ref_data_i = '0;
   endtask

   task automatic commit(input bit side_dut, input int ch, input logic [31:0] a, input logic [31:0] d);
      if (side_dut) begin
         dut_vld_i[ch] = 1'b1; dut_addr_i[ch*32 +: 32] = a; dut_data_i[ch*32 +: 32] = d;
      end else begin
         ref_vld_i[ch] = 1'b1; ref_addr_i[ch*32 +: 32] = a; ref_data_i[ch*32 +: 32] = d;
      end
   endtask

   // reset, then enable and let the FSM reach RUN
   task automatic start();
      clear_in();
      en_i = 1'b0;
      reset_i = 1'b1;
      tick(2);
      reset_i = 1'b0;
      en_i = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      clear_in();
      en_i = 1'b0;
      reset_i = 1'b1;
      #1;
      vectors++; if (state_o !== 2'b00) begin miscompares++; $display("FAIL reset_state: got %b want 00", state_o); end
      vectors++; if (match_cnt_o !== 32'd0) begin miscompares++; $display("FAIL reset_match_cnt: got %0d want 0", match_cnt_o); end
      vectors++; if ({err_o, err_code_o, err_ch_o} !== 4'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0000", {err_o, err_code_o, err_ch_o}); end
      tick();
      reset_i = 1'b0;
      en_i = 1'b1;
      tick();
      vectors++; if (state_o !== 2'b01) begin miscompares++; $display("FAIL idle_to_run: got %b want 01", state_o); end
      en_i = 1'b0;
      tick();
      vectors++; if (state_o !== 2'b00) begin miscompares++; $display("FAIL run_to_idle: got %b want 00", state_o); end
      $display("reset/enable sequence: state=%b match_cnt=%0d", state_o, match_cnt_o);
   endtask

   task automatic test_single_match();
      start();
      commit(1, 0, 32'd5, 32'h12);
      commit(0, 0, 32'd5, 32'h12);
      tick();
      clear_in();
      vectors++; if (match_cnt_o !== 32'd0) begin miscompares++; $display("FAIL single_latency: got %0d want 0", match_cnt_o); end
      tick();
      vectors++; if (match_cnt_o !== 32'd1) begin miscompares++; $display("FAIL single_match_cnt: got %0d want 1", match_cnt_o); end
      vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL single_err: got %b want 0", err_o); end
      $display("single match: match_cnt=%0d err=%b", match_cnt_o, err_o);
   endtask

   task automatic test_ref_lead();
      start();
      for (int cyc = 0; cyc < 7; cyc++) begin
         clear_in();
         if (cyc < 4)  commit(0, 0, 32'(cyc), 32'h100 + 32'(cyc));
         if (cyc >= 3) commit(1, 0, 32'(cyc - 3), 32'h100 + 32'(cyc - 3));
         tick();
      end
      clear_in();
      tick(2);
      vectors++; if (match_cnt_o !== 32'd4) begin miscompares++; $display("FAIL lead_match_cnt: got %0d want 4", match_cnt_o); end
      vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL lead_err: got %b want 0", err_o); end
      $display("ref lead by 3: match_cnt=%0d err=%b", match_cnt_o, err_o);
   endtask

   task automatic test_mismatch();
      start();
      commit(1, 1, 32'h100, 32'hAA);
      commit(0, 1, 32'h100, 32'hAB);
      tick();
      clear_in();
      tick();
      vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL mism_err: got %b want 1", err_o); end
      vectors++; if (err_code_o !== 2'b01) begin miscompares++; $display("FAIL mism_code: got %b want 01", err_code_o); end
      vectors++; if (err_ch_o !== 1'b1) begin miscompares++; $display("FAIL mism_ch: got %0d want 1", err_ch_o); end
      vectors++; if (err_addr_o !== 32'h100) begin miscompares++; $display("FAIL mism_addr: got %h want 100", err_addr_o); end
      vectors++; if (err_dut_data_o !== 32'hAA) begin miscompares++; $display("FAIL mism_dut_data: got %h want aa", err_dut_data_o); end
      vectors++; if (err_ref_data_o !== 32'hAB) begin miscompares++; $display("FAIL mism_ref_data: got %h want ab", err_ref_data_o); end
      vectors++; if (state_o !== ST_AFTER_ERR) begin miscompares++; $display("FAIL mism_state: got %b want %b", state_o, ST_AFTER_ERR); end
      vectors++; if (match_cnt_o !== 32'd0) begin miscompares++; $display("FAIL mism_match_cnt: got %0d want 0", match_cnt_o); end
      $display("mismatch ch1: err=%b code=%b ch=%0d dut=%h ref=%h state=%b", err_o, err_code_o, err_ch_o, err_dut_data_o, err_ref_data_o, state_o);
   endtask

   task automatic test_overflow();
      start();
      for (int k = 0; k < 8; k++) begin
         clear_in();
         commit(1, 0, 32'(k), 32'(k));
         tick();
      end
      clear_in();
      vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL ovf_full_no_err: got %b want 0", err_o); end
      commit(1, 0, 32'd8, 32'd8);
      tick();
      clear_in();
      vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL ovf_err: got %b want 1", err_o); end
      vectors++; if (err_code_o !== 2'b10) begin miscompares++; $display("FAIL ovf_code: got %b want 10", err_code_o); end
      vectors++; if (err_ch_o !== 1'b0) begin miscompares++; $display("FAIL ovf_ch: got %0d want 0", err_ch_o); end
      $display("overflow ch0: err=%b code=%b ch=%0d", err_o, err_code_o, err_ch_o);
   endtask

   task automatic test_timeout();
      start();
      commit(1, 0, 32'd7, 32'd7);
      tick();
      clear_in();
      tick(63);
      vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL tmo_early: got %b want 0", err_o); end
      tick();
      vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL tmo_err: got %b want 1", err_o); end
      vectors++; if (err_code_o !== 2'b11) begin miscompares++; $display("FAIL tmo_code: got %b want 11", err_code_o); end
      $display("timeout ch0: err=%b code=%b", err_o, err_code_o);
   endtask

   task automatic test_back_to_back();
      start();
      for (int k = 0; k < 5; k++) begin
         clear_in();
         for (int c = 0; c < 2; c++) begin
            commit(1, c, 32'(k * 2 + c), 32'hC0 + 32'(k));
            commit(0, c, 32'(k * 2 + c), 32'hC0 + 32'(k));
         end
         tick();
      end
      clear_in();
      tick();
      vectors++; if (match_cnt_o !== 32'd10) begin miscompares++; $display("FAIL b2b_match_cnt: got %0d want 10", match_cnt_o); end
      vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL b2b_err: got %b want 0", err_o); end
      $display("back-to-back both channels: match_cnt=%0d", match_cnt_o);
   endtask

   task automatic test_dual_mismatch();
      start();
      commit(1, 0, 32'd1, 32'd1);
      commit(0, 0, 32'd1, 32'd2);
      commit(1, 1, 32'd2, 32'd3);
      commit(0, 1, 32'd2, 32'd4);
      tick();
      clear_in();
      tick();
      vectors++; if (err_ch_o !== 1'b0) begin miscompares++; $display("FAIL dual_ch: got %0d want 0", err_ch_o); end
      vectors++; if (err_code_o !== 2'b01) begin miscompares++; $display("FAIL dual_code: got %b want 01", err_code_o); end
      vectors++; if ({err_dut_data_o, err_ref_data_o} !== {32'd1, 32'd2}) begin miscompares++; $display("FAIL dual_data: got %h/%h want 1/2", err_dut_data_o, err_ref_data_o); end
      reset_i = 1'b1;
      #1;
      vectors++; if ({state_o, err_o, err_code_o, err_ch_o} !== 6'b0) begin miscompares++; $display("FAIL dual_reset_flags: got %b want 000000", {state_o, err_o, err_code_o, err_ch_o}); end
      vectors++; if ({err_addr_o, err_dut_data_o, err_ref_data_o, match_cnt_o} !== 128'b0) begin miscompares++; $display("FAIL dual_reset_data: got %h want 0", {err_addr_o, err_dut_data_o, err_ref_data_o, match_cnt_o}); end
      tick();
      reset_i = 1'b0;
      $display("dual mismatch then reset: state=%b err=%b", state_o, err_o);
   endtask

   initial begin
      clear_in();
      en_i = 1'b0;
      reset_i = 1'b1;
      test_reset();
      test_single_match();
      test_ref_lead();
      test_mismatch();
      test_overflow();
      test_timeout();
      test_back_to_back();
      test_dual_mismatch();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
